// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: next-PC select codes,
// the bubble instruction word and the fetch FSM state type.
package fetch_stage_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'b00,
        ST_HOLD    = 2'b01,
        ST_DISCARD = 2'b10
    } fetch_state_t;

    // MIPS J-type target: keep the 256 MB region of the delay-slot PC.
    function automatic logic [31:0] jump_target(input logic [3:0]  pc4_region,
                                                input logic [25:0] jump_index);
        return {pc4_region, jump_index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next fetch address select: sequential, ID-stage branch target or J-type
// jump built from the instruction currently held in IF/ID.
module fetch_next_pc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [3:0]  pc4_region,
    input  logic [25:0] jump_index,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc + 32'd4;
        case (pc_src)
            PCSRC_BR: next_pc = branch_target;
            PCSRC_J:  next_pc = jump_target(pc4_region, jump_index);
            default:  next_pc = pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and IF/ID register, runs the imem req/ack
// handshake and squashes in-flight fetches on branch/jump redirects.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_WAIT    | request outstanding for address pc
//   ST_HOLD    | word arrived during a stall, parked in hold; no request
//   ST_DISCARD | request for a squashed address still open; its data is dropped
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        if_id_bubble,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    fetch_state_t state, state_nx;
    logic [31:0]  hold, hold_nx;
    logic [31:0]  stale_addr, stale_addr_nx;
    logic [31:0]  pc_nx, instr_nx, pc4_nx;
    logic         valid_nx;
    logic [31:0]  next_pc, pc_plus4;
    logic         stall, flush, fetch_ok;

    fetch_next_pc u_next_pc (
        .pc            (pc),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .pc4_region    (if_id_pc4[31:28]),
        .jump_index    (if_id_instr[25:0]),
        .next_pc       (next_pc)
    );

    assign pc_plus4 = pc + 32'd4;
    assign stall    = ~pc_write | ~if_id_write;
    assign flush    = if_id_bubble | (pc_src != PCSRC_SEQ);

    // Gated by rst_n so a request is dropped in the reset cycle itself.
    assign imem_req  = rst_n & (state != ST_HOLD);
    assign imem_addr = (state == ST_DISCARD) ? stale_addr : pc;
    assign fetch_ok  = imem_req & imem_ack;

    always_comb begin
        state_nx      = state;
        hold_nx       = hold;
        stale_addr_nx = stale_addr;
        pc_nx         = pc;
        instr_nx      = if_id_instr;
        pc4_nx        = if_id_pc4;
        valid_nx      = if_id_valid;

        if (flush || (!stall && !(state == ST_HOLD) &&
                      !(state == ST_WAIT && fetch_ok))) begin
            instr_nx = NOP_INSTR;
            pc4_nx   = 32'h0;
            valid_nx = 1'b0;
        end

        case (state)
            ST_WAIT: begin
                if (flush) begin
                    pc_nx = next_pc;
                    if (!fetch_ok) begin
                        state_nx      = ST_DISCARD;
                        stale_addr_nx = pc;
                    end
                end else if (fetch_ok && !stall) begin
                    instr_nx = imem_rdata;
                    pc4_nx   = pc_plus4;
                    valid_nx = 1'b1;
                    pc_nx    = pc_plus4;
                end else if (fetch_ok) begin
                    hold_nx  = imem_rdata;
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_nx    = next_pc;
                    hold_nx  = 32'h0;
                    state_nx = ST_WAIT;
                end else if (!stall) begin
                    instr_nx = hold;
                    pc4_nx   = pc_plus4;
                    valid_nx = 1'b1;
                    pc_nx    = pc_plus4;
                    hold_nx  = 32'h0;
                    state_nx = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                if (flush) begin
                    pc_nx = next_pc;
                end
                if (fetch_ok) begin
                    state_nx = ST_WAIT;
                end
            end
            default: begin
                state_nx = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_WAIT;
            hold        <= 32'h0;
            stale_addr  <= 32'h0;
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            hold        <= hold_nx;
            stale_addr  <= stale_addr_nx;
            pc          <= pc_nx;
            if_id_instr <= instr_nx;
            if_id_pc4   <= pc4_nx;
            if_id_valid <= valid_nx;
        end
    end

endmodule
